// File: rtl/spi_dac_pkg.sv
// ----------------------------------------------------------------------------
// spi_dac_pkg
//   Shared definitions for the DAC8411-style SPI link. Used by the spi_main_x2
//   transmitter users and by the spi_sub_rx receiver.
//   Contents:
//     frame_width()  frame length in bits for a given data word width
//     PD_*           power_state field encodings
//     rx_state_t     receiver FSM state encoding
// ----------------------------------------------------------------------------
package spi_dac_pkg;

    // A frame is {power_state[1:0], word}, so two bits longer than the word.
    function automatic int unsigned frame_width(input int unsigned word_width);
        return word_width + 32'd2;
    endfunction

    localparam logic [1:0] PD_NORMAL = 2'b00;
    localparam logic [1:0] PD_1K     = 2'b01;
    localparam logic [1:0] PD_100K   = 2'b10;
    localparam logic [1:0] PD_HIZ    = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// ----------------------------------------------------------------------------
// spi_sync_edge
//   Two-flop synchroniser for one asynchronous input, followed by a
//   previous-value register so that single-cycle edge pulses can be decoded
//   in the i_clk domain. All three flops reset to RST_VAL so that a pin
//   sitting at its idle level produces no edge when reset is released.
//   Ports:
//     i_clk    system clock
//     i_rst_n  asynchronous active-low reset
//     i_d      asynchronous input pin
//     o_level  synchronised level
//     o_rise   one-cycle pulse on synchronised 0->1
//     o_fall   one-cycle pulse on synchronised 1->0
// ----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_sub_rx.sv
// ----------------------------------------------------------------------------
// spi_sub_rx
//   SPI subordinate receiver for {power_state[1:0], word} frames, MSB first.
//   sclk/mosi/csb are oversampled in the sys_clk domain (sys_clk must be at
//   least 4x sclk). A frame is accepted only if exactly FRAME_W sclk falls
//   occurred while csb was low; it is then presented on a valid/ready output
//   register.
//   Ports:
//     sys_clk, rst_n        clock / asynchronous active-low reset
//     sclk, mosi, csb       SPI pins (sclk idles high, data sampled on fall)
//     out_ready             consumer accepts the held frame
//     out_valid             frame held in output register
//     out_word, out_power   received word / power_state bits
//     frame_err             1-cycle pulse: frame closed with wrong bit count
//     overrun               1-cycle pulse: good frame dropped (output full)
//     busy                  synchronised csb is low
//     err_count, ovr_count  saturating pulse counters (SPI_SUB_RX_STATS_EN)
//   Optional feature: define SPI_SUB_RX_STATS_EN to add the statistics ports.
// ----------------------------------------------------------------------------
module spi_sub_rx
    import spi_dac_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 16
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  csb,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [WORD_WIDTH-1:0] out_word,
    output logic [1:0]            out_power,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
`ifdef SPI_SUB_RX_STATS_EN
   ,output logic [7:0]            err_count,
    output logic [7:0]            ovr_count
`endif
);

    localparam int unsigned FRAME_W = frame_width(WORD_WIDTH);
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    // ------------------------------------------------------------------
    // Pin synchronisers
    // ------------------------------------------------------------------
    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_csb_s,  w_csb_rise,  w_csb_fall;
    logic w_mosi_s, w_mosi_rise, w_mosi_fall;

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_sclk (
        .i_clk   (sys_clk),
        .i_rst_n (rst_n),
        .i_d     (sclk),
        .o_level (w_sclk_s),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_csb (
        .i_clk   (sys_clk),
        .i_rst_n (rst_n),
        .i_d     (csb),
        .o_level (w_csb_s),
        .o_rise  (w_csb_rise),
        .o_fall  (w_csb_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .i_clk   (sys_clk),
        .i_rst_n (rst_n),
        .i_d     (mosi),
        .o_level (w_mosi_s),
        .o_rise  (w_mosi_rise),
        .o_fall  (w_mosi_fall)
    );

    // Channel outputs that this receiver has no use for.
    logic w_unused;
    assign w_unused = &{1'b0, w_sclk_s, w_sclk_rise, w_mosi_rise, w_mosi_fall};

    // ------------------------------------------------------------------
    // Next shift/count values. The FSM uses these (not the registers) when
    // checking the count on csb rise, so a bit arriving in the same cycle
    // as the csb rise is counted before the frame is judged.
    // ------------------------------------------------------------------
    logic [FRAME_W-1:0] r_shift;
    logic [CNT_W-1:0]   r_count;
    logic [FRAME_W-1:0] w_shift_next;
    logic [CNT_W-1:0]   w_count_next;

    always_comb begin
        w_shift_next = r_shift;
        w_count_next = r_count;
        if (w_sclk_fall) begin
            w_shift_next = {r_shift[FRAME_W-2:0], w_mosi_s};
            // Saturate one past a full frame so any long frame stays "long".
            if (r_count != CNT_SAT) begin
                w_count_next = r_count + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM with registered outputs
    // ------------------------------------------------------------------
    rx_state_t         r_state;
    logic              r_out_valid;
    logic [WORD_WIDTH-1:0] r_out_word;
    logic [1:0]        r_out_power;
    logic              r_frame_err;
    logic              r_overrun;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_power <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // Handshake completes; a frame loaded below overrides this.
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_csb_fall) begin
                        r_shift <= '0;
                        r_count <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shift <= w_shift_next;
                    r_count <= w_count_next;
                    if (w_csb_rise) begin
                        r_state <= IDLE;
                        if (w_count_next == CNT_FULL) begin
                            if (!r_out_valid || out_ready) begin
                                r_out_valid <= 1'b1;
                                r_out_word  <= w_shift_next[WORD_WIDTH-1:0];
                                r_out_power <= w_shift_next[FRAME_W-1:WORD_WIDTH];
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_word  = r_out_word;
    assign out_power = r_out_power;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = ~w_csb_s;

`ifdef SPI_SUB_RX_STATS_EN
    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    logic [7:0] r_err_count;
    logic [7:0] r_ovr_count;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
            r_ovr_count <= '0;
        end else begin
            if (r_frame_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 8'd1;
            end
            if (r_overrun && (r_ovr_count != '1)) begin
                r_ovr_count <= r_ovr_count + 8'd1;
            end
        end
    end

    assign err_count = r_err_count;
    assign ovr_count = r_ovr_count;
`endif

endmodule

// File: tb/tb_spi_sub_rx.sv
// ----------------------------------------------------------------------------
// tb_spi_sub_rx
//   Self-checking bench for spi_sub_rx. An SPI main model drives frames at
//   sys_clk/4; a monitor counts output beats and status pulses. Build with
//   SPI_SUB_RX_STATS_EN defined to also exercise the statistics counters.
// ----------------------------------------------------------------------------
module tb_spi_sub_rx;
    import spi_dac_pkg::*;

    localparam int unsigned WW = 16;

    logic          sys_clk   = 1'b0;
    logic          rst_n     = 1'b0;
    logic          sclk      = 1'b1;
    logic          mosi      = 1'b0;
    logic          csb       = 1'b1;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic [WW-1:0] out_word;
    logic [1:0]    out_power;
    logic          frame_err;
    logic          overrun;
    logic          busy;
`ifdef SPI_SUB_RX_STATS_EN
    logic [7:0]    err_count;
    logic [7:0]    ovr_count;
`endif

    always #5 sys_clk = ~sys_clk;

    spi_sub_rx #(.WORD_WIDTH(WW)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .csb       (csb),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .out_power (out_power),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
`ifdef SPI_SUB_RX_STATS_EN
       ,.err_count (err_count),
        .ovr_count (ovr_count)
`endif
    );

    // ------------------------------------------------------------------
    // Scoreboard counters and check helper
    // ------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: samples 1 time unit after each falling sys_clk edge, i.e.
    // the values the DUT will see at the next rising edge.
    // ------------------------------------------------------------------
    int          mon_valid_cycles = 0;
    int          mon_beats        = 0;
    int          mon_err          = 0;
    int          mon_ovr          = 0;
    logic [15:0] beat_word[$];
    logic [1:0]  beat_pow[$];

    always @(negedge sys_clk) begin
        #1;
        if (rst_n) begin
            if (out_valid) mon_valid_cycles++;
            if (out_valid && out_ready) begin
                mon_beats++;
                beat_word.push_back(out_word);
                beat_pow.push_back(out_power);
            end
            if (frame_err) mon_err++;
            if (overrun)   mon_ovr++;
        end
    end

    task automatic clear_mon();
        mon_valid_cycles = 0;
        mon_beats        = 0;
        mon_err          = 0;
        mon_ovr          = 0;
        beat_word.delete();
        beat_pow.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // ------------------------------------------------------------------
    // SPI main model: sclk half period = 2 sys_clk. mosi changes on sclk
    // rise; bits past the 18-bit frame are sent as 0.
    // ------------------------------------------------------------------
    task automatic spi_bits(input logic [17:0] f, input int nbits);
        csb  = 1'b0;
        mosi = f[17];
        tick(2);
        for (int k = 0; k < nbits; k++) begin
            sclk = 1'b0;
            tick(2);
            sclk = 1'b1;
            mosi = (k + 1 < 18) ? f[17 - (k + 1)] : 1'b0;
            tick(2);
        end
    endtask

    task automatic spi_close();
        csb  = 1'b1;
        mosi = 1'b0;
        tick(6);
    endtask

    task automatic send_frame(input logic [1:0] pw, input logic [15:0] w, input int nbits);
        spi_bits({pw, w}, nbits);
        spi_close();
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]  pw;
        logic [15:0] w;
        int          nbits;
        int          exp_beats;
        int          exp_err;
        logic [15:0] exp_word;
        logic [1:0]  exp_pow;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{PD_1K,     16'hA5C3, 18, 1, 0, 16'hA5C3, 2'b01};
        vecs[1] = '{PD_HIZ,    16'h0000, 18, 1, 0, 16'h0000, 2'b11};
        vecs[2] = '{PD_HIZ,    16'hFFFF, 18, 1, 0, 16'hFFFF, 2'b11};
        vecs[3] = '{PD_HIZ,    16'h8001, 18, 1, 0, 16'h8001, 2'b11};
        vecs[4] = '{PD_100K,   16'h1234, 10, 0, 1, 16'h0000, 2'b00};
        vecs[5] = '{PD_NORMAL, 16'h1234, 19, 0, 1, 16'h0000, 2'b00};
        vecs[6] = '{PD_NORMAL, 16'hBEEF, 17, 0, 1, 16'h0000, 2'b00};
        vecs[7] = '{PD_NORMAL, 16'h0000,  0, 0, 1, 16'h0000, 2'b00};
        vecs[8] = '{PD_1K,     16'h0F0F, 50, 0, 1, 16'h0000, 2'b00};
        vecs[9] = '{PD_100K,   16'h0001, 18, 1, 0, 16'h0001, 2'b10};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        tick(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_word",  32'(out_word),  32'd0);
        check("rst_out_power", 32'(out_power), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        rst_n = 1'b1;
        tick(4);

        // ---------------- table-driven frames, out_ready=1 ----------------
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clear_mon();
            send_frame(vecs[i].pw, vecs[i].w, vecs[i].nbits);
            tick(2);
            check($sformatf("v%0d_beats", i),        32'(mon_beats),        32'(vecs[i].exp_beats));
            check($sformatf("v%0d_valid_cycles", i), 32'(mon_valid_cycles), 32'(vecs[i].exp_beats));
            check($sformatf("v%0d_frame_err", i),    32'(mon_err),          32'(vecs[i].exp_err));
            check($sformatf("v%0d_overrun", i),      32'(mon_ovr),          32'd0);
            if (vecs[i].exp_beats == 1 && beat_word.size() > 0) begin
                check($sformatf("v%0d_word", i),  32'(beat_word[0]), 32'(vecs[i].exp_word));
                check($sformatf("v%0d_power", i), 32'(beat_pow[0]),  32'(vecs[i].exp_pow));
            end
        end

        // ---------------- back-to-back frames, ordered beats ----------------
        clear_mon();
        send_frame(PD_HIZ, 16'h0000, 18);
        send_frame(PD_HIZ, 16'hFFFF, 18);
        send_frame(PD_HIZ, 16'h8001, 18);
        tick(2);
        check("b2b_beats", 32'(mon_beats), 32'd3);
        if (beat_word.size() == 3) begin
            check("b2b_word0", 32'(beat_word[0]), 32'h0000);
            check("b2b_word1", 32'(beat_word[1]), 32'hFFFF);
            check("b2b_word2", 32'(beat_word[2]), 32'h8001);
            check("b2b_pow2",  32'(beat_pow[2]),  32'd3);
        end

        // ---------------- overrun with out_ready=0 ----------------
        clear_mon();
        out_ready = 1'b0;
        send_frame(PD_NORMAL, 16'h1111, 18);
        send_frame(PD_NORMAL, 16'h2222, 18);
        tick(2);
        check("ovr_valid_held", 32'(out_valid), 32'd1);
        check("ovr_word_held",  32'(out_word),  32'h1111);
        check("ovr_pulses",     32'(mon_ovr),   32'd1);
        check("ovr_no_err",     32'(mon_err),   32'd0);
        out_ready = 1'b1;
        tick(1);
        #2;
        check("ovr_valid_drop", 32'(out_valid), 32'd0);
        check("ovr_beats",      32'(mon_beats), 32'd1);
        if (beat_word.size() > 0) begin
            check("ovr_beat_word", 32'(beat_word[0]), 32'h1111);
        end
        tick(2);

        // ---------------- reset mid-frame ----------------
        clear_mon();
        spi_bits({PD_NORMAL, 16'h5A5A}, 9);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        csb   = 1'b1;
        sclk  = 1'b1;
        mosi  = 1'b0;
        tick(1);
        check("mid_rst_busy",  32'(busy),      32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(4);
        send_frame(PD_NORMAL, 16'h5A5A, 18);
        tick(2);
        check("mid_err",   32'(mon_err),   32'd0);
        check("mid_ovr",   32'(mon_ovr),   32'd0);
        check("mid_beats", 32'(mon_beats), 32'd1);
        if (beat_word.size() > 0) begin
            check("mid_word", 32'(beat_word[0]), 32'h5A5A);
        end

`ifdef SPI_SUB_RX_STATS_EN
        // ---------------- statistics saturation ----------------
        rst_n = 1'b0;
        tick(2);
        check("stats_rst_err", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        tick(4);
        clear_mon();
        for (int n = 0; n < 300; n++) begin
            send_frame(PD_NORMAL, 16'h0000, 10);
        end
        tick(2);
        check("stats_err_pulses", 32'(mon_err),   32'd300);
        check("stats_err_count",  32'(err_count), 32'd255);
        check("stats_ovr_count",  32'(ovr_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
